// File: rtl/tcam_route_loader_if.sv
// Command/response handshake bundle for tcam_route_loader.
// The host drives commands and the loader returns one status per command.
interface tcam_route_loader_if #(
    parameter int WIDTH = 32,
    parameter int IFW   = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_net;
    logic [5:0]       cmd_plen;
    logic [IFW-1:0]   cmd_if;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2:0]       rsp_code;
    logic [7:0]       rsp_index;

    modport master (
        output cmd_valid, cmd_op, cmd_net, cmd_plen, cmd_if, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_code, rsp_index
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_net, cmd_plen, cmd_if, rsp_ready,
        output cmd_ready, rsp_valid, rsp_code, rsp_index
    );
endinterface

// File: rtl/tcam_route_loader.sv
// TCAM route-table writer: add/delete/flush with a shadow table for lookups.
// TCAM_LOADER_FLUSH_ON_RESET_EN: invalidate every TCAM slot after reset.
module tcam_route_loader #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 8,
    parameter int IFW   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    tcam_route_loader_if.slave     bus,
    output logic                   wr_en,
    output logic [7:0]             wr_index,
    output logic [2*WIDTH+IFW:0]   wr_data,
    output logic [8:0]             entry_count
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_FLUSH = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [2:0] RC_OK_ADD   = 3'd0;
    localparam logic [2:0] RC_OK_UPD   = 3'd1;
    localparam logic [2:0] RC_OK_DEL   = 3'd2;
    localparam logic [2:0] RC_NOTFOUND = 3'd3;
    localparam logic [2:0] RC_FULL     = 3'd4;
    localparam logic [2:0] RC_BADCMD   = 3'd5;
    localparam logic [2:0] RC_OK_FLUSH = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_FLUSH,
`ifdef TCAM_LOADER_FLUSH_ON_RESET_EN
        S_INIT,
`endif
        S_RESP
    } state_t;

`ifdef TCAM_LOADER_FLUSH_ON_RESET_EN
    localparam state_t RST_STATE = S_INIT;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t state, state_n;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] net_q;
    logic [WIDTH-1:0] mask_q;
    logic [5:0]       plen_q;
    logic [IFW-1:0]   if_q;
    logic [7:0]       idx_q;
    logic             hit_q, free_q;
    logic [7:0]       hidx_q, fidx_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [2:0]       rsp_code_q, dec_code;
    logic [7:0]       rsp_index_q, dec_idx;

    logic [SIZE-1:0]  sh_v;
    logic [WIDTH-1:0] sh_net  [SIZE];
    logic [5:0]       sh_plen [SIZE];

    function automatic logic [WIDTH-1:0] mk_mask(input logic [5:0] p);
        mk_mask = {WIDTH{1'b1}} << (7'(WIDTH) - {1'b0, p});
    endfunction

    logic             accept, bad_cmd, last;
    logic [IW-1:0]    slot, tgt;
    logic             cur_match, cur_free;
    logic             hit_n, free_n;
    logic [7:0]       hidx_n, fidx_n;
    logic [WIDTH-1:0] cmd_mask;

    assign accept    = bus.cmd_valid & cmd_ready_q;
    assign bad_cmd   = (bus.cmd_op == OP_RSVD) ||
                       ({1'b0, bus.cmd_plen} > 7'(WIDTH));
    assign cmd_mask  = mk_mask(bus.cmd_plen);
    assign last      = (idx_q == 8'(SIZE - 1));
    assign slot      = idx_q[IW-1:0];
    assign tgt       = rsp_index_q[IW-1:0];
    assign cur_match = sh_v[slot] && (sh_plen[slot] == plen_q) &&
                       (sh_net[slot] == net_q);
    assign cur_free  = !sh_v[slot];
    assign hit_n     = hit_q | cur_match;
    assign hidx_n    = hit_q ? hidx_q : idx_q;
    assign free_n    = free_q | cur_free;
    assign fidx_n    = free_q ? fidx_q : idx_q;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_code  = rsp_code_q;
    assign bus.rsp_index = rsp_index_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RST_STATE;
        else     state <= state_n;
    end

    // Next state and the response code decided when leaving IDLE or SCAN.
    always_comb begin
        state_n  = state;
        dec_code = rsp_code_q;
        dec_idx  = rsp_index_q;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bad_cmd) begin
                        state_n  = S_RESP;
                        dec_code = RC_BADCMD;
                        dec_idx  = 8'd0;
                    end else if (bus.cmd_op == OP_FLUSH) begin
                        state_n  = S_FLUSH;
                        dec_code = RC_OK_FLUSH;
                        dec_idx  = 8'd0;
                    end else begin
                        state_n  = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (last) begin
                    if (op_q == OP_ADD) begin
                        if (hit_n) begin
                            state_n  = S_WRITE;
                            dec_code = RC_OK_UPD;
                            dec_idx  = hidx_n;
                        end else if (free_n) begin
                            state_n  = S_WRITE;
                            dec_code = RC_OK_ADD;
                            dec_idx  = fidx_n;
                        end else begin
                            state_n  = S_RESP;
                            dec_code = RC_FULL;
                            dec_idx  = 8'd0;
                        end
                    end else if (hit_n) begin
                        state_n  = S_WRITE;
                        dec_code = RC_OK_DEL;
                        dec_idx  = hidx_n;
                    end else begin
                        state_n  = S_RESP;
                        dec_code = RC_NOTFOUND;
                        dec_idx  = 8'd0;
                    end
                end
            end
            S_WRITE: state_n = S_RESP;
            S_FLUSH: if (last) state_n = S_RESP;
`ifdef TCAM_LOADER_FLUSH_ON_RESET_EN
            S_INIT:  if (last) state_n = S_IDLE;
`endif
            S_RESP:  if (rsp_valid_q && bus.rsp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Command latch, slot scan, TCAM write port and shadow table.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= 2'd0;
            net_q       <= '0;
            mask_q      <= '0;
            plen_q      <= 6'd0;
            if_q        <= '0;
            idx_q       <= 8'd0;
            hit_q       <= 1'b0;
            free_q      <= 1'b0;
            hidx_q      <= 8'd0;
            fidx_q      <= 8'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= 3'd0;
            rsp_index_q <= 8'd0;
            wr_en       <= 1'b0;
            wr_index    <= 8'd0;
            wr_data     <= '0;
            entry_count <= 9'd0;
            sh_v        <= '0;
        end else begin
            wr_en       <= 1'b0;
            cmd_ready_q <= (state_n == S_IDLE);
            rsp_code_q  <= dec_code;
            rsp_index_q <= dec_idx;
            rsp_valid_q <= (state == S_RESP) &&
                           !(rsp_valid_q && bus.rsp_ready);
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= bus.cmd_op;
                        net_q  <= bus.cmd_net & cmd_mask;
                        mask_q <= cmd_mask;
                        plen_q <= bus.cmd_plen;
                        if_q   <= bus.cmd_if;
                        idx_q  <= 8'd0;
                        hit_q  <= 1'b0;
                        free_q <= 1'b0;
                        hidx_q <= 8'd0;
                        fidx_q <= 8'd0;
                    end
                end
                S_SCAN: begin
                    hit_q  <= hit_n;
                    hidx_q <= hidx_n;
                    free_q <= free_n;
                    fidx_q <= fidx_n;
                    idx_q  <= idx_q + 8'd1;
                end
                S_WRITE: begin
                    wr_en    <= 1'b1;
                    wr_index <= rsp_index_q;
                    if (op_q == OP_ADD) begin
                        wr_data       <= {1'b1, net_q, mask_q, if_q};
                        sh_v[tgt]     <= 1'b1;
                        sh_net[tgt]   <= net_q;
                        sh_plen[tgt]  <= plen_q;
                        if (rsp_code_q == RC_OK_ADD)
                            entry_count <= entry_count + 9'd1;
                    end else begin
                        wr_data     <= '0;
                        sh_v[tgt]   <= 1'b0;
                        entry_count <= entry_count - 9'd1;
                    end
                end
                S_FLUSH: begin
                    wr_en       <= 1'b1;
                    wr_index    <= idx_q;
                    wr_data     <= '0;
                    idx_q       <= idx_q + 8'd1;
                    sh_v        <= '0;
                    entry_count <= 9'd0;
                end
`ifdef TCAM_LOADER_FLUSH_ON_RESET_EN
                S_INIT: begin
                    wr_en    <= 1'b1;
                    wr_index <= idx_q;
                    wr_data  <= '0;
                    idx_q    <= idx_q + 8'd1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
